// File: rtl/fifo_wr_framer.sv
// Write-side frame encapsulator: wraps each producer frame as header (sequence
// number), payload, checksum trailer and pushes it into the FIFO write port.
module fifo_wr_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_write_data,
  input  logic                  fifo_full,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    ob_valid_q, ob_valid_d;
  logic [DATA_WIDTH-1:0]   ob_data_q, ob_data_d;
  logic [DATA_WIDTH-1:0]   seq_q, seq_d;
  logic [DATA_WIDTH-1:0]   csum_q, csum_d;
  logic [CNT_WIDTH-1:0]    frame_count_q, frame_count_d;

  logic                    adv;
  logic                    load;
  logic [DATA_WIDTH-1:0]   load_data;

  // The output register can take a new word when it is empty or its word is
  // being accepted by the FIFO on this same edge.
  assign adv = !ob_valid_q || !fifo_full;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d       = state_q;
    seq_d         = seq_q;
    csum_d        = csum_q;
    frame_count_d = frame_count_q;
    in_ready      = 1'b0;
    load          = 1'b0;
    load_data     = '0;

    unique case (state_q)
      IDLE: begin
        if (in_valid && adv) begin
          load      = 1'b1;
          load_data = seq_q;
          csum_d    = '0;
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        in_ready = adv;
        if (in_valid && adv) begin
          load      = 1'b1;
          load_data = in_data;
          csum_d    = csum_q + in_data;
          if (in_last) state_d = TRAILER;
        end
      end
      TRAILER: begin
        if (adv) begin
          load          = 1'b1;
          load_data     = csum_q;
          seq_d         = seq_q + DATA_WIDTH'(1);
          frame_count_d = frame_count_q + CNT_WIDTH'(1);
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Data is only replaced on a load, so it stays put while the FIFO is full.
    ob_valid_d = ob_valid_q;
    ob_data_d  = ob_data_q;
    if (load) begin
      ob_valid_d = 1'b1;
      ob_data_d  = load_data;
    end else if (ob_valid_q && !fifo_full) begin
      ob_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ob_valid_q    <= 1'b0;
      ob_data_q     <= '0;
      seq_q         <= '0;
      csum_q        <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ob_valid_q    <= ob_valid_d;
      ob_data_q     <= ob_data_d;
      seq_q         <= seq_d;
      csum_q        <= csum_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign fifo_wr_en      = ob_valid_q;
  assign fifo_write_data = ob_data_q;
  assign frame_count     = frame_count_q;
  assign busy            = (state_q != IDLE) || ob_valid_q;

endmodule

// File: doc/fifo_wr_framer.md
# fifo_wr_framer

Write-side frame encapsulator sitting directly upstream of the asynchronous FIFO in the `wr_clk` domain. It accepts a byte stream from the producer over a valid/ready handshake with an end-of-frame marker. For each frame it pushes a sequence-number header, the payload and a checksum trailer into the FIFO write port. It honours FIFO `full` so that no word is ever lost or duplicated.

## Interface
- `DATA_WIDTH`, 8: width of payload, header and trailer words; must match the FIFO `DATA_WIDTH`.
- `CNT_WIDTH`, 16: width of the `frame_count` status counter.

- `wr_clk`  in  1  write-domain clock; all logic is rising-edge.
- `rst`  in  1  reset: asynchronous, active-high; clock `wr_clk`.
- `in_valid`  in  1  producer has a payload word on `in_data`.
- `in_ready`  out  1  framer accepts `in_data` this cycle; transfer occurs when `in_valid && in_ready`.
- `in_data`  in  DATA_WIDTH  payload word.
- `in_last`  in  1  qualifies `in_data` as the final payload word of the frame.
- `fifo_wr_en`  out  1  write request to the FIFO; registered.
- `fifo_write_data`  out  DATA_WIDTH  word to write; registered.
- `fifo_full`  in  1  FIFO full flag; a write is accepted at an edge only when `fifo_wr_en && !fifo_full`.
- `frame_count`  out  CNT_WIDTH  number of frames whose trailer has been loaded; wraps modulo 2^CNT_WIDTH.
- `busy`  out  1  high when state != IDLE or the output register holds a word.

## Operation
- **Output register.** `ob_valid` and `ob_data` drive `fifo_wr_en` and `fifo_write_data`.
  - `adv = !ob_valid || !fifo_full`.
  - The register may load a new word only when `adv`.
  - When `ob_valid && !fifo_full` and nothing is loaded, `ob_valid` clears.
  - While `fifo_full` is high, `ob_data` is held stable.
- **Internal registers.** `seq` (DATA_WIDTH), `csum` (DATA_WIDTH) and `state`.
- **FSM states:** IDLE, PAYLOAD, TRAILER.
  - **IDLE.** `in_ready = 0`. If `in_valid && adv`: load `ob_data <= seq`, `csum <= 0`, go to PAYLOAD. No input word is consumed.
  - **PAYLOAD.** `in_ready = adv`. On transfer: `ob_data <= in_data`, `csum <= csum + in_data` (mod 2^DATA_WIDTH). If `in_last`, go to TRAILER.
  - **TRAILER.** `in_ready = 0`. If `adv`: `ob_data <= csum`, `seq <= seq + 1` (wraps), `frame_count <= frame_count + 1`, go to IDLE.
- **Frame size.** A frame of N payload words (N ≥ 1) produces exactly N+2 FIFO writes: header = seq, N payload words, trailer = sum of the payload mod 2^DATA_WIDTH.
- **Input handshake.** `in_data`, `in_last` and `in_valid` must stay stable while `in_valid && !in_ready`. The framer never drops or reorders words.
- **Empty frames** are impossible: a frame begins only with a valid payload word.

## Timing
- **Reset values:** `fifo_wr_en` 0, `fifo_write_data` 0, `in_ready` 0, `frame_count` 0, `busy` 0; `seq` 0, `csum` 0, state IDLE.
- **Latency.** With `fifo_full` low:
  - `in_valid` rising in IDLE → header on the FIFO port 1 cycle later.
  - The first payload word is accepted on the cycle after the header is loaded.
  - Each payload word appears on the FIFO port the cycle after its transfer.
  - The trailer appears 1 cycle after the `in_last` transfer.
- **Throughput.** Back-to-back frames take N+2 cycles each, with `fifo_wr_en` continuously high.
- **Backpressure.** A `fifo_full` assertion stalls the FSM the same cycle (`adv = 0`, `in_ready = 0`). The held word is written on the first edge with `fifo_full` low.
- **Simultaneous write and load.** Accepting the current word and loading the next occur on the same edge, with no bubble.
- **Reset mid-frame.** All registers clear immediately. The partial frame is abandoned, and the next frame's header is 0x00. The FIFO shares `rst`, so it is cleared too.

## Test plan
- **Single frame.** Payload 0x10, 0x20, 0x30 (last on 0x30), `fifo_full` = 0 → FIFO writes 0x00, 0x10, 0x20, 0x30, 0x60 on consecutive cycles; `frame_count` = 1.
- **Back-to-back frames.** Second frame 0xAA (last) immediately after the first → writes 0x01, 0xAA, 0xAA; no idle cycle between the two frames; `frame_count` = 2.
- **Backpressure.** Hold `fifo_full` = 1 for 5 cycles while 0x20 is in the output register → `fifo_wr_en` stays 1, data stays 0x20, `in_ready` stays 0; the full write sequence is unchanged afterwards.
- **Checksum wrap.** Payload 0xFF, 0x02 → trailer 0x01.
- **Sequence wrap.** After 256 single-word frames, the header of frame 257 is 0x00 and `frame_count` = 257.
- **Reset mid-frame.** Pulse `rst` after 2 payload words → outputs at reset values the same cycle; the next frame 0x05 (last) writes 0x00, 0x05, 0x05.
